jtag_debug_scan_master: RTL and testbench

- Initiator side of the 2-bit-IR virtual JTAG interface that the CPU debug module's TCK/sysclk pair listens on.
- Takes one scan command at a time over a valid/ready port and drives the IR-update, capture, shift and update sequence onto the vji_* wires. It generates TCK from clk.
- Returns the 38-bit word shifted out of the debug module on tdo, plus the 2-bit ir_out status.
- Used as an on-chip debug initiator and as the drive source for simulation in place of the JTAG hub.

---
 rtl/jtag_scan_pkg.sv | 27 ++
 rtl/jtag_scan_tck_gen.sv | 44 ++++
 rtl/jtag_debug_scan_master.sv | 167 ++++++++++++++++
 tb/tb_jtag_debug_scan_master.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_scan_pkg
// Description : Shared types and constants for the virtual JTAG scan master.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_scan_pkg;

    localparam int DEFAULT_DR_WIDTH = 38;
    localparam int DEFAULT_IR_WIDTH = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_scan_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : jtag_scan_tck_gen
// Description : Divides clk into TCK phases; rise/fall strobes mark the edges.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_scan_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise,
    output logic o_fall
);

    localparam int                 C_CNT_W   = $clog2(2 * TCK_DIV);
    localparam logic [C_CNT_W-1:0] C_RISE_AT = C_CNT_W'(TCK_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_FALL_AT = C_CNT_W'(2 * TCK_DIV - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_tck;

    assign o_rise = i_en && (r_cnt == C_RISE_AT);
    assign o_fall = i_en && (r_cnt == C_FALL_AT);
    assign o_tck  = r_tck;

    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else begin
            r_cnt <= o_fall ? '0 : r_cnt + 1'b1;
            if (o_rise) begin
                r_tck <= 1'b1;
            end else if (o_fall) begin
                r_tck <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_debug_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_debug_scan_master
// Description : Virtual JTAG initiator: one UIR/CDR/SDR/UDR/RTI scan per command.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_debug_scan_master
    import jtag_scan_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int                 C_BIT_W    = $clog2(DR_WIDTH + 1);
    localparam logic [C_BIT_W-1:0] C_LAST_BIT = C_BIT_W'(DR_WIDTH - 1);

    scan_state_t         r_state, w_state_nxt;
    logic [DR_WIDTH-1:0] r_tx, w_tx_nxt;
    logic [DR_WIDTH-1:0] r_rx;
    logic [C_BIT_W-1:0]  r_bit_cnt, w_bit_nxt;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_uir, r_cdr, r_sdr, r_udr, r_rti, r_tdi;
    logic                w_uir_nxt, w_cdr_nxt, w_sdr_nxt, w_udr_nxt, w_rti_nxt, w_tdi_nxt;
    logic                r_rsp_valid;
    logic [DR_WIDTH-1:0] r_rsp_data;
    logic [IR_WIDTH-1:0] r_rsp_ir_out;
    logic                w_accept, w_en, w_rise, w_fall;

    assign cmd_ready = (r_state == IDLE) && !r_rsp_valid;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_en      = (r_state != IDLE);

    jtag_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_en),
        .o_tck  (vji_tck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transitions only happen at acceptance or a phase end, so the strobes
    // decoded from the next state are registered exactly at phase boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_bit_nxt   = r_bit_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = UIR;
                    w_tx_nxt    = cmd_data;
                    w_bit_nxt   = '0;
                end
            end
            UIR: if (w_fall) w_state_nxt = CDR;
            CDR: if (w_fall) w_state_nxt = SDR;
            SDR: begin
                if (w_fall) begin
                    w_tx_nxt = r_tx >> 1;
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_state_nxt = UDR;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            UDR: if (w_fall) w_state_nxt = RTI;
            RTI: if (w_fall) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_uir_nxt = (w_state_nxt == UIR);
        w_cdr_nxt = (w_state_nxt == CDR);
        w_sdr_nxt = (w_state_nxt == SDR);
        w_udr_nxt = (w_state_nxt == UDR);
        w_rti_nxt = (w_state_nxt == RTI) || (w_state_nxt == IDLE);
        w_tdi_nxt = (w_state_nxt == SDR) && w_tx_nxt[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx         <= '0;
            r_rx         <= '0;
            r_bit_cnt    <= '0;
            r_ir_in      <= '0;
            r_uir        <= 1'b0;
            r_cdr        <= 1'b0;
            r_sdr        <= 1'b0;
            r_udr        <= 1'b0;
            r_rti        <= 1'b1;
            r_tdi        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_ir_out <= '0;
        end else begin
            r_tx      <= w_tx_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_uir     <= w_uir_nxt;
            r_cdr     <= w_cdr_nxt;
            r_sdr     <= w_sdr_nxt;
            r_udr     <= w_udr_nxt;
            r_rti     <= w_rti_nxt;
            r_tdi     <= w_tdi_nxt;
            if (w_accept) begin
                r_ir_in <= cmd_ir;
            end
            // Target shifts on the same TCK rise, so tdo here is the pre-shift bit.
            if (w_rise && (r_state == SDR)) begin
                r_rx <= {vji_tdo, r_rx[DR_WIDTH-1:1]};
            end
            if (w_rise && (r_state == UDR)) begin
                r_rsp_ir_out <= vji_ir_out;
            end
            if (w_fall && (r_state == RTI)) begin
                r_rsp_data  <= r_rx;
                r_rsp_valid <= 1'b1;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign vji_tdi    = r_tdi;
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = r_uir;
    assign vji_cdr    = r_cdr;
    assign vji_sdr    = r_sdr;
    assign vji_udr    = r_udr;
    assign vji_rti    = r_rti;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_ir_out = r_rsp_ir_out;

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_debug_scan_master
// Description : Randomized bench with a virtual JTAG target model for the master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_debug_scan_master;
    import jtag_scan_pkg::IR_BREAK;
    import jtag_scan_pkg::IR_TRACECTRL;

    localparam int DR    = 38;
    localparam int LAT_A = 1 + 2 * 2 * (DR + 4);
    localparam int LAT_B = 1 + 2 * 1 * (DR + 4);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset;
    int   errs = 0;
    int   checks = 0;

    // instance A (TCK_DIV=2)
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]    cmd_ir, rsp_ir_out, ir_in, ir_out;
    logic [DR-1:0] cmd_data, rsp_data;
    logic          tck, tdi, tdo, uir, cdr, sdr, udr, rti;
    // instance B (TCK_DIV=1)
    logic          cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
    logic [1:0]    cmd_ir_b, rsp_ir_out_b, ir_in_b, ir_out_b;
    logic [DR-1:0] cmd_data_b, rsp_data_b;
    logic          tck_b, tdi_b, tdo_b, uir_b, cdr_b, sdr_b, udr_b, rti_b;

    jtag_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(2), .TCK_DIV(2)) u_dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .vji_tck(tck), .vji_tdi(tdi),
        .vji_tdo(tdo), .vji_ir_in(ir_in), .vji_ir_out(ir_out), .vji_uir(uir),
        .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti));

    jtag_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(2), .TCK_DIV(1)) u_dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_ir_out(rsp_ir_out_b),
        .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_in_b),
        .vji_ir_out(ir_out_b), .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b),
        .vji_udr(udr_b), .vji_rti(rti_b));

    // Target models: capture a word at CDR, shift tdi in at the top on SDR.
    logic [DR-1:0] tgt_cap = '0, tgt_sr = '0, tgt_cap_b = '0, tgt_sr_b = '0;
    logic [1:0]    tgt_irout = 2'b00;
    always @(posedge tck) begin
        if (cdr) tgt_sr <= tgt_cap;
        else if (sdr) tgt_sr <= {tdi, tgt_sr[DR-1:1]};
    end
    always @(posedge tck_b) begin
        if (cdr_b) tgt_sr_b <= tgt_cap_b;
        else if (sdr_b) tgt_sr_b <= {tdi_b, tgt_sr_b[DR-1:1]};
    end
    assign tdo      = tgt_sr[0];
    assign tdo_b    = tgt_sr_b[0];
    assign ir_out   = tgt_irout;
    assign ir_out_b = 2'b00;

    // Monitors: accumulate per-rise observations; scans compare against snapshots.
    int   m_sdr = 0, m_uir = 0, m_cdr = 0, m_udr = 0, m_irbad = 0, m_sdr_b = 0;
    logic tdi_q[$];
    logic tdi_q_b[$];
    logic [1:0] exp_ir = 2'b00;
    always @(posedge tck) begin
        if (uir) m_uir++;
        if (cdr) m_cdr++;
        if (udr) m_udr++;
        if (sdr) begin
            tdi_q.push_back(tdi);
            m_sdr++;
        end
        if (ir_in != exp_ir) m_irbad++;
    end
    always @(posedge tck_b) begin
        if (sdr_b) begin
            tdi_q_b.push_back(tdi_b);
            m_sdr_b++;
        end
    end

    int            s_sdr, s_uir, s_cdr, s_udr, s_irbad, s_q, t_acc, lat;
    logic [DR-1:0] exp_tx, exp_cap;
    logic [1:0]    exp_io;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tck"}, tck, 1'b0);
        check({tag, "_strobes"}, {uir, cdr, sdr, udr, tdi}, 5'b0);
        check({tag, "_rti"}, rti, 1'b1);
        check({tag, "_ir_in"}, ir_in, 2'b00);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_data"}, rsp_data, '0);
        check({tag, "_rsp_ir_out"}, rsp_ir_out, 2'b00);
    endtask

    task automatic prep_cmd(input logic [1:0] ir, input logic [DR-1:0] d,
                            input logic [DR-1:0] cap, input logic [1:0] io);
        exp_ir = ir; exp_tx = d; exp_cap = cap; exp_io = io;
        tgt_cap = cap; tgt_irout = io;
        s_sdr = m_sdr; s_uir = m_uir; s_cdr = m_cdr; s_udr = m_udr;
        s_irbad = m_irbad; s_q = tdi_q.size();
    endtask

    task automatic start_cmd(input logic [1:0] ir, input logic [DR-1:0] d,
                             input logic [DR-1:0] cap, input logic [1:0] io);
        int n;
        prep_cmd(ir, d, cap, io);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ir = ir; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("accept_timeout", 1'b0, 1'b1);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_ir = ~ir; cmd_data = ~d;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("rsp_timeout", 1'b0, 1'b1);
        lat = cyc - t_acc;
    endtask

    task automatic check_scan(input string tag);
        logic [DR-1:0] w;
        w = '0;
        for (int i = 0; i < DR; i++)
            if (s_q + i < tdi_q.size()) w[i] = tdi_q[s_q + i];
        check({tag, "_latency"}, lat, LAT_A);
        check({tag, "_rsp_data"}, rsp_data, exp_cap);
        check({tag, "_rsp_ir_out"}, rsp_ir_out, exp_io);
        check({tag, "_tdi_stream"}, w, exp_tx);
        check({tag, "_sdr_rises"}, m_sdr - s_sdr, DR);
        check({tag, "_uir_rises"}, m_uir - s_uir, 1);
        check({tag, "_cdr_rises"}, m_cdr - s_cdr, 1);
        check({tag, "_udr_rises"}, m_udr - s_udr, 1);
        check({tag, "_ir_in_held"}, m_irbad - s_irbad, 0);
    endtask

    task automatic consume(input string tag);
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        check({tag, "_rsp_cleared"}, rsp_valid, 1'b0);
    endtask

    function automatic logic [DR-1:0] rnd_dr();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DR-1:0];
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DR-1:0] hold, d2, cap2, w;
        logic          stable, rdy_low, saw;
        int            n, dly, tck_bad, k;

        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
        cmd_valid_b = 1'b0; cmd_ir_b = '0; cmd_data_b = '0; rsp_ready_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        check("reset_b_tck", tck_b, 1'b0);
        check("reset_b_cmd_ready", cmd_ready_b, 1'b1);

        start_cmd(IR_BREAK, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 2'b00);
        wait_rsp();
        check_scan("basic");
        consume("basic");

        start_cmd(IR_TRACECTRL, rnd_dr(), rnd_dr(), 2'b01);
        wait_rsp();
        check_scan("irout");
        check("irout_ir_in", ir_in, 2'b11);
        consume("irout");

        // Backpressure with the next command already waiting.
        start_cmd(2'($urandom), rnd_dr(), rnd_dr(), 2'($urandom));
        wait_rsp();
        check_scan("bp1");
        hold = rsp_data;
        d2 = rnd_dr(); cap2 = rnd_dr();
        prep_cmd(2'($urandom), d2, cap2, 2'($urandom));
        cmd_valid = 1'b1; cmd_ir = exp_ir; cmd_data = d2;
        stable = 1'b1; rdy_low = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_data !== hold || rsp_valid !== 1'b1) stable = 1'b0;
            if (cmd_ready !== 1'b0) rdy_low = 1'b0;
        end
        check("bp_rsp_held", stable, 1'b1);
        check("bp_cmd_ready_low", rdy_low, 1'b1);
        rsp_ready = 1'b1;
        check("bp_ready_at_handshake", cmd_ready, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_rsp_cleared", rsp_valid, 1'b0);
        check("bp_ready_after", cmd_ready, 1'b1);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = ~d2;
        wait_rsp();
        check_scan("bp2");
        consume("bp2");

        // Reset in the middle of the shift.
        start_cmd(2'($urandom), rnd_dr(), rnd_dr(), 2'($urandom));
        n = 0;
        while ((m_sdr - s_sdr) < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_sdr10", m_sdr - s_sdr, 10);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        saw = 1'b0;
        repeat (250) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        check("midrst_no_rsp", saw, 1'b0);
        start_cmd(2'($urandom), rnd_dr(), rnd_dr(), 2'($urandom));
        wait_rsp();
        check_scan("after_rst");
        consume("after_rst");

        for (int i = 0; i < 4; i++) begin
            start_cmd(2'($urandom), rnd_dr(), rnd_dr(), 2'($urandom));
            wait_rsp();
            check_scan($sformatf("rnd%0d", i));
            dly = $urandom_range(0, 5);
            repeat (dly) @(negedge clk);
            check($sformatf("rnd%0d_hold", i), rsp_data, exp_cap);
            consume($sformatf("rnd%0d", i));
        end

        // TCK_DIV=1 instance.
        tgt_cap_b = rnd_dr();
        n = m_sdr_b;
        k = tdi_q_b.size();
        @(negedge clk);
        cmd_valid_b = 1'b1; cmd_ir_b = IR_BREAK; cmd_data_b = 38'h3F_FFFF_FFFF;
        check("div1_ready", cmd_ready_b, 1'b1);
        t_acc = cyc;
        tck_bad = 0;
        @(negedge clk);
        cmd_valid_b = 1'b0; cmd_data_b = '0;
        dly = 0;
        while (!rsp_valid_b && dly < 500) begin
            if ((cyc - t_acc) <= LAT_B - 1) begin
                if (tck_b !== (((cyc - t_acc) % 2) == 0)) tck_bad++;
            end else if (tck_b !== 1'b0) tck_bad++;
            @(negedge clk);
            dly++;
        end
        check("div1_latency", cyc - t_acc, LAT_B);
        check("div1_tck_toggle", tck_bad, 0);
        check("div1_rsp_data", rsp_data_b, tgt_cap_b);
        check("div1_sdr_rises", m_sdr_b - n, DR);
        w = '0;
        for (int i = 0; i < DR; i++)
            if (k + i < tdi_q_b.size()) w[i] = tdi_q_b[k + i];
        check("div1_tdi_stream", w, 38'h3F_FFFF_FFFF);
        @(negedge clk); rsp_ready_b = 1'b1;
        @(negedge clk); rsp_ready_b = 1'b0;
        check("div1_rsp_cleared", rsp_valid_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
